// File: rtl/aer_event_receiver.sv
// aer_event_receiver: timestamps and captures arbiter address-events, queues them in a
// first-word-fall-through FIFO and returns a fixed-length release pulse per event.
`default_nettype none

module aer_event_receiver #(
  parameter int ADDR_W     = 2,
  parameter int TS_W       = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int ACK_CYCLES = 2
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic                            enable_i,
  input  logic                            active_i,
  input  logic [ADDR_W-1:0]               x_add_i,
  input  logic [ADDR_W-1:0]               y_add_i,
  output logic                            ack_o,
  output logic                            evt_valid_o,
  output logic [TS_W+2*ADDR_W-1:0]        evt_data_o,
  input  logic                            evt_ready_i,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_count_o,
  output logic                            stall_o
);

  localparam int DATA_W = TS_W + 2*ADDR_W;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int ACK_W  = $clog2(ACK_CYCLES + 1);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(FIFO_DEPTH);
  localparam logic [ACK_W-1:0] ACK_LOAD  = ACK_W'(ACK_CYCLES);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CAPTURE  = 2'd1,
    ACK      = 2'd2,
    WAIT_LOW = 2'd3
  } state_t;

  state_t              state, state_next;
  logic [TS_W-1:0]     ts;
  logic [DATA_W-1:0]   evt_latch;
  logic [ACK_W-1:0]    ack_cnt, ack_cnt_next;
  logic [DATA_W-1:0]   mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic [CNT_W-1:0]    count, count_next;
  logic                latch_en, push, pop, full;
  logic                ack_q, stall_q;

  assign full = (count == FULL_CNT);
  assign pop  = (count != '0) && evt_ready_i;

  always_comb begin
    state_next   = state;
    ack_cnt_next = ack_cnt;
    latch_en     = 1'b0;
    push         = 1'b0;
    if (!enable_i) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (active_i) begin
            latch_en   = 1'b1;
            state_next = CAPTURE;
          end
        end
        CAPTURE: begin
          // A full FIFO holds the event here and withholds the ack as backpressure.
          if (!full) begin
            push         = 1'b1;
            ack_cnt_next = ACK_LOAD;
            state_next   = ACK;
          end
        end
        ACK: begin
          if (ack_cnt <= ACK_W'(1)) state_next = WAIT_LOW;
          else                      ack_cnt_next = ack_cnt - ACK_W'(1);
        end
        WAIT_LOW: begin
          if (!active_i) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
    count_next = count + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state     <= IDLE;
      ts        <= '0;
      evt_latch <= '0;
      ack_cnt   <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      ack_q     <= 1'b0;
      stall_q   <= 1'b0;
    end else begin
      state   <= state_next;
      ack_cnt <= ack_cnt_next;
      count   <= count_next;
      if (enable_i) ts <= ts + TS_W'(1);
      if (latch_en) evt_latch <= {ts, x_add_i, y_add_i};
      if (push)     wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)      rd_ptr <= rd_ptr + PTR_W'(1);
      // Flopped copies of the state decode keep the arbiter-facing outputs glitch-free.
      ack_q   <= (state_next == ACK);
      stall_q <= (state_next == CAPTURE) && (count_next == FULL_CNT);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i && push) mem[wr_ptr] <= evt_latch;
  end

  assign ack_o        = ack_q;
  assign stall_o      = stall_q;
  assign evt_valid_o  = (count != '0);
  assign evt_data_o   = evt_valid_o ? mem[rd_ptr] : '0;
  assign fifo_count_o = count;

endmodule

`default_nettype wire
